// File: rtl/eeprom_pkg.sv
// Shared definitions for the EEPROM APB arbiter: FSM state encoding,
// APB data width and the default watchdog limit.
package eeprom_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   localparam int APB_DW          = 32;
   localparam int DEFAULT_TIMEOUT = 1000000;

endpackage

// File: rtl/eeprom_apb_arbiter_if.sv
// APB link between the arbiter (master side) and the apb_eeprom slave port.
interface eeprom_apb_arbiter_if
   import eeprom_pkg::*;
#(
   parameter int AWIDTH = 10
);

   logic [AWIDTH-1:0] paddr;
   logic              pwrite;
   logic              psel;
   logic              penable;
   logic [APB_DW-1:0] pwdata;
   logic [APB_DW-1:0] prdata;
   logic              pready;
   logic              pslverr;

   modport master (
      output paddr, pwrite, psel, penable, pwdata,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  paddr, pwrite, psel, penable, pwdata,
      output prdata, pready, pslverr
   );

endinterface

// File: rtl/eeprom_rr_pick.sv
// Combinational round-robin picker: rotate requests so the search starts
// just after the last winner, take the lowest set bit, rotate the index back.
module eeprom_rr_pick #(
   parameter int NREQ = 2,
   parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   last,
   output logic [NREQ-1:0] win_oh,
   output logic [IW-1:0]   win_idx,
   output logic            win_valid
);

   localparam logic [IW:0] NSUM = (IW+1)'(NREQ);

   logic [IW-1:0]     start;
   logic [2*NREQ-1:0] dbl;
   logic [2*NREQ-1:0] dbl_sh;
   logic [NREQ-1:0]   rot;
   logic [IW-1:0]     off;
   logic [IW:0]       sum;

   always_comb begin
      start     = (last == IW'(NREQ-1)) ? '0 : last + IW'(1);
      dbl       = {req, req};
      dbl_sh    = dbl >> start;
      rot       = dbl_sh[NREQ-1:0];
      off       = '0;
      win_valid = 1'b0;
      for (int j = 0; j < NREQ; j++) begin
         if (!win_valid && rot[j]) begin
            win_valid = 1'b1;
            off       = IW'(j);
         end
      end
      // Undo the rotation: winner index is (start + offset) mod NREQ.
      sum     = {1'b0, start} + {1'b0, off};
      win_idx = (sum >= NSUM) ? IW'(sum - NSUM) : sum[IW-1:0];
      win_oh  = win_valid ? (NREQ'(1) << win_idx) : '0;
   end

endmodule

// File: rtl/eeprom_apb_arbiter.sv
// Round-robin arbiter sharing one APB EEPROM slave among NREQ requesters,
// sequencing SETUP/ACCESS transfers with a pready watchdog.
module eeprom_apb_arbiter
   import eeprom_pkg::*;
#(
   parameter int NREQ    = 2,
   parameter int AWIDTH  = 10,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ-1:0]          req_write,
   input  logic [NREQ*AWIDTH-1:0]   req_addr,
   input  logic [NREQ*APB_DW-1:0]   req_wdata,
   output logic [NREQ-1:0]          gnt,
   output logic [NREQ-1:0]          done,
   output logic                     err,
   output logic [APB_DW-1:0]        rdata,
   output logic                     busy,
   eeprom_apb_arbiter_if.master     apb
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   state_t            state;
   logic [IW-1:0]     last;
   logic [CW-1:0]     cnt;

   logic [NREQ-1:0]   pick_oh;
   logic [IW-1:0]     pick_idx;
   logic              pick_valid;

   logic [AWIDTH-1:0] sel_addr;
   logic [APB_DW-1:0] sel_wdata;
   logic              sel_write;
   logic              tmo_hit;
   logic              finish;

   eeprom_rr_pick #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_pick (
      .req       (req),
      .last      (last),
      .win_oh    (pick_oh),
      .win_idx   (pick_idx),
      .win_valid (pick_valid)
   );

   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      sel_write = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (pick_oh[i]) begin
            sel_addr  = req_addr[i*AWIDTH +: AWIDTH];
            sel_wdata = req_wdata[i*APB_DW +: APB_DW];
            sel_write = req_write[i];
         end
      end
   end

   // pready takes precedence over a coincident watchdog expiry.
   assign tmo_hit = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));
   assign finish  = (state == ACCESS) && (apb.pready || tmo_hit);
   assign done    = finish ? gnt : '0;
   assign err     = finish && (apb.pready ? apb.pslverr : 1'b1);
   assign rdata   = apb.prdata;
   assign busy    = (state != IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         last        <= IW'(NREQ - 1);
         cnt         <= '0;
         gnt         <= '0;
         apb.psel    <= 1'b0;
         apb.penable <= 1'b0;
         apb.pwrite  <= 1'b0;
         apb.paddr   <= '0;
         apb.pwdata  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  gnt         <= pick_oh;
                  last        <= pick_idx;
                  apb.paddr   <= sel_addr;
                  apb.pwdata  <= sel_wdata;
                  apb.pwrite  <= sel_write;
                  apb.psel    <= 1'b1;
                  apb.penable <= 1'b0;
                  cnt         <= '0;
                  state       <= SETUP;
               end
            end
            SETUP: begin
               apb.penable <= 1'b1;
               state       <= ACCESS;
            end
            ACCESS: begin
               if (finish) begin
                  gnt         <= '0;
                  apb.psel    <= 1'b0;
                  apb.penable <= 1'b0;
                  state       <= IDLE;
               end else if (cnt != '1) begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: begin
               gnt         <= '0;
               apb.psel    <= 1'b0;
               apb.penable <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_eeprom_apb_arbiter.sv
// Directed bench for eeprom_apb_arbiter (NREQ=2, AWIDTH=10, TIMEOUT=16):
// hand-computed expectations checked with immediate assertions.
module tb_eeprom_apb_arbiter;
   import eeprom_pkg::*;

   logic        clk;
   logic        rst_n;
   logic [1:0]  req;
   logic [1:0]  req_write;
   logic [19:0] req_addr;
   logic [63:0] req_wdata;
   logic [1:0]  gnt;
   logic [1:0]  done;
   logic        err;
   logic [31:0] rdata;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   eeprom_apb_arbiter_if #(.AWIDTH(10)) apb ();

   eeprom_apb_arbiter #(
      .NREQ    (2),
      .AWIDTH  (10),
      .TIMEOUT (16)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .gnt       (gnt),
      .done      (done),
      .err       (err),
      .rdata     (rdata),
      .busy      (busy),
      .apb       (apb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic applyStimulus(input logic [1:0] r, input logic [1:0] w,
                                input logic [9:0] a0, input logic [9:0] a1,
                                input logic [31:0] d0, input logic [31:0] d1);
      req       = r;
      req_write = w;
      req_addr  = {a1, a0};
      req_wdata = {d1, d0};
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout observed=running expected=finished");
      $fatal(1, "[TB] simulation time limit");
   end

   initial begin
      rst_n = 1'b0;
      applyStimulus(2'b00, 2'b00, 10'h0, 10'h0, 32'h0, 32'h0);
      apb.prdata  = 32'h0;
      apb.pready  = 1'b0;
      apb.pslverr = 1'b0;

      // Reset state
      step(); step(); #1;
      checkOutput("rst_psel",    32'(apb.psel),    32'd0);
      checkOutput("rst_penable", 32'(apb.penable), 32'd0);
      checkOutput("rst_pwrite",  32'(apb.pwrite),  32'd0);
      checkOutput("rst_paddr",   32'(apb.paddr),   32'd0);
      checkOutput("rst_pwdata",  apb.pwdata,       32'd0);
      checkOutput("rst_gnt",     32'(gnt),         32'd0);
      checkOutput("rst_busy",    32'(busy),        32'd0);
      checkOutput("rst_done",    32'(done),        32'd0);
      checkOutput("rst_err",     32'(err),         32'd0);
      rst_n = 1'b1;
      step();

      // Single read from requester 0, pready on the 3rd ACCESS cycle
      applyStimulus(2'b01, 2'b00, 10'h005, 10'h0, 32'h0, 32'h0);
      step(); #1;
      checkOutput("rd_setup_psel",    32'(apb.psel),    32'd1);
      checkOutput("rd_setup_penable", 32'(apb.penable), 32'd0);
      checkOutput("rd_setup_gnt",     32'(gnt),         32'd1);
      checkOutput("rd_setup_paddr",   32'(apb.paddr),   32'h005);
      checkOutput("rd_setup_pwrite",  32'(apb.pwrite),  32'd0);
      checkOutput("rd_setup_busy",    32'(busy),        32'd1);
      step(); #1;
      checkOutput("rd_acc1_penable",  32'(apb.penable), 32'd1);
      checkOutput("rd_acc1_done",     32'(done),        32'd0);
      step(); #1;
      checkOutput("rd_acc2_done",     32'(done),        32'd0);
      step();
      apb.pready = 1'b1;
      apb.prdata = 32'hA5A5A5A5;
      applyStimulus(2'b00, 2'b00, 10'h005, 10'h0, 32'h0, 32'h0);
      #1;
      checkOutput("rd_done",  32'(done), 32'd1);
      checkOutput("rd_err",   32'(err),  32'd0);
      checkOutput("rd_rdata", rdata,     32'hA5A5A5A5);
      step();
      apb.pready = 1'b0;
      #1;
      checkOutput("rd_idle_psel", 32'(apb.psel), 32'd0);
      checkOutput("rd_idle_gnt",  32'(gnt),      32'd0);
      checkOutput("rd_idle_busy", 32'(busy),     32'd0);
      checkOutput("rd_idle_done", 32'(done),     32'd0);

      // Fairness from a fresh reset: both held, grants alternate 0,1,0,1
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      applyStimulus(2'b11, 2'b00, 10'h010, 10'h020, 32'h0, 32'h0);
      for (int k = 0; k < 4; k++) begin
         logic [1:0] exp_gnt;
         exp_gnt = (k % 2 == 0) ? 2'b01 : 2'b10;
         step(); #1;
         checkOutput("rr_gnt",   32'(gnt),         32'(exp_gnt));
         checkOutput("rr_paddr", 32'(apb.paddr),   (k % 2 == 0) ? 32'h010 : 32'h020);
         checkOutput("rr_setup", 32'(apb.penable), 32'd0);
         step();
         apb.pready = 1'b1;
         if (k == 3) applyStimulus(2'b00, 2'b00, 10'h010, 10'h020, 32'h0, 32'h0);
         #1;
         checkOutput("rr_done", 32'(done), 32'(exp_gnt));
         step();
         apb.pready = 1'b0;
         #1;
         checkOutput("rr_idle_busy", 32'(busy), 32'd0);
         checkOutput("rr_idle_gnt",  32'(gnt),  32'd0);
      end

      // Write from requester 1; its inputs change during SETUP
      applyStimulus(2'b10, 2'b10, 10'h0, 10'h03F, 32'h0, 32'h11223344);
      step(); #1;
      checkOutput("wr_gnt",    32'(gnt),        32'd2);
      checkOutput("wr_pwrite", 32'(apb.pwrite), 32'd1);
      checkOutput("wr_paddr",  32'(apb.paddr),  32'h03F);
      checkOutput("wr_pwdata", apb.pwdata,      32'h11223344);
      applyStimulus(2'b10, 2'b00, 10'h0, 10'h000, 32'h0, 32'h0);
      step(); #1;
      checkOutput("wr_acc_pwdata", apb.pwdata,      32'h11223344);
      checkOutput("wr_acc_paddr",  32'(apb.paddr),  32'h03F);
      checkOutput("wr_acc_pwrite", 32'(apb.pwrite), 32'd1);
      step();
      apb.pready = 1'b1;
      applyStimulus(2'b00, 2'b00, 10'h0, 10'h0, 32'h0, 32'h0);
      #1;
      checkOutput("wr_done",       32'(done),  32'd2);
      checkOutput("wr_err",        32'(err),   32'd0);
      checkOutput("wr_end_pwdata", apb.pwdata, 32'h11223344);
      step();
      apb.pready = 1'b0;
      #1;
      checkOutput("wr_idle_busy", 32'(busy), 32'd0);

      // Slave error on requester 0
      applyStimulus(2'b01, 2'b00, 10'h100, 10'h0, 32'h0, 32'h0);
      step(); #1;
      checkOutput("se_gnt", 32'(gnt), 32'd1);
      step();
      apb.pready  = 1'b1;
      apb.pslverr = 1'b1;
      applyStimulus(2'b00, 2'b00, 10'h100, 10'h0, 32'h0, 32'h0);
      #1;
      checkOutput("se_done", 32'(done), 32'd1);
      checkOutput("se_err",  32'(err),  32'd1);
      step();
      apb.pready  = 1'b0;
      apb.pslverr = 1'b0;
      #1;
      checkOutput("se_after_done", 32'(done), 32'd0);
      checkOutput("se_after_err",  32'(err),  32'd0);

      // Watchdog: requester 1 times out, requester 0 queued behind it
      applyStimulus(2'b11, 2'b00, 10'h0AA, 10'h0BB, 32'h0, 32'h0);
      step(); #1;
      checkOutput("to_gnt", 32'(gnt), 32'd2);
      for (int i = 1; i <= 16; i++) begin
         step(); #1;
         if (i < 16) begin
            checkOutput("to_wait_done", 32'(done), 32'd0);
         end else begin
            checkOutput("to_done", 32'(done), 32'd2);
            checkOutput("to_err",  32'(err),  32'd1);
            applyStimulus(2'b01, 2'b00, 10'h0AA, 10'h0BB, 32'h0, 32'h0);
         end
      end
      step(); #1;
      checkOutput("to_psel_drop", 32'(apb.psel), 32'd0);
      checkOutput("to_idle_busy", 32'(busy),     32'd0);
      step(); #1;
      checkOutput("to_next_gnt",   32'(gnt),       32'd1);
      checkOutput("to_next_paddr", 32'(apb.paddr), 32'h0AA);
      step();
      apb.pready = 1'b1;
      applyStimulus(2'b00, 2'b00, 10'h0AA, 10'h0BB, 32'h0, 32'h0);
      #1;
      checkOutput("to_next_done", 32'(done), 32'd1);
      checkOutput("to_next_err",  32'(err),  32'd0);
      step();
      apb.pready = 1'b0;

      // Reset while requester 1 is in ACCESS
      applyStimulus(2'b10, 2'b00, 10'h0, 10'h1C0, 32'h0, 32'h0);
      step(); step(); #1;
      checkOutput("mr_gnt",     32'(gnt),         32'd2);
      checkOutput("mr_penable", 32'(apb.penable), 32'd1);
      rst_n = 1'b0;
      step(); #1;
      checkOutput("mr_psel", 32'(apb.psel), 32'd0);
      checkOutput("mr_gnt0", 32'(gnt),      32'd0);
      checkOutput("mr_done", 32'(done),     32'd0);
      checkOutput("mr_busy", 32'(busy),     32'd0);
      rst_n = 1'b1;
      applyStimulus(2'b11, 2'b00, 10'h011, 10'h1C0, 32'h0, 32'h0);
      step(); #1;
      checkOutput("mr_regnt", 32'(gnt), 32'd1);
      step();
      apb.pready = 1'b1;
      applyStimulus(2'b00, 2'b00, 10'h011, 10'h1C0, 32'h0, 32'h0);
      #1;
      checkOutput("mr_redone", 32'(done), 32'd1);
      step();
      apb.pready = 1'b0;
      #1;
      checkOutput("mr_idle_busy", 32'(busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/eeprom_apb_arbiter.md
# eeprom_apb_arbiter

Round-robin arbiter and APB master sequencer that shares one `apb_eeprom` slave port between up to four requesters. Examples of requesters are a UI controller and a config loader. It latches each granted request and drives a standard APB SETUP/ACCESS transfer. It returns read data, a completion pulse and an error flag to the winning requester. A watchdog terminates transfers whose `pready` never arrives.

## Interface
- `NREQ`, 2: number of requesters, 2..4.
- `AWIDTH`, 10: APB address width.
- `TIMEOUT`, 1000000: maximum ACCESS cycles before forced termination; 0 disables the watchdog.
- `clk` input 1: system clock.
- `rst_n` input 1: reset, synchronous, active-low.
- `req` input NREQ: per-requester request level.
- `req_write` input NREQ: 1 = write, 0 = read.
- `req_addr` input NREQ*AWIDTH: flattened addresses; requester i uses bits [i*AWIDTH +: AWIDTH].
- `req_wdata` input NREQ*32: flattened write data.
- `gnt` output NREQ: one-hot owner of the transfer in progress.
- `done` output NREQ: one-cycle completion strobe to the owner.
- `err` output 1: qualifies `done`; 1 on `pslverr` or timeout.
- `rdata` output 32: equals `prdata`; valid only while `done` is set.
- `busy` output 1: high when not IDLE.
- `paddr`, `pwrite`, `psel`, `penable`, `pwdata` outputs AWIDTH/1/1/1/32: APB master.
- `prdata`, `pready`, `pslverr` inputs 32/1/1: APB slave response.

## Operation
- The FSM has three states: IDLE, SETUP and ACCESS.
- In IDLE, when any `req` bit is high:
  - Pick a winner by round robin. The search starts at `last+1` mod NREQ. `last` resets to NREQ-1, so requester 0 has first priority after reset.
  - Register the winner's `req_write`, `req_addr` and `req_wdata` into the APB output registers.
  - Set `gnt` to the winner, update `last`, then go to SETUP.
- SETUP: `psel`=1, `penable`=0. Always moves to ACCESS after one cycle.
- ACCESS: `psel`=1, `penable`=1. The watchdog counter increments each cycle.
- On `pready`=1 in ACCESS:
  - `done[owner]`=1 combinationally in that same cycle.
  - `err`=`pslverr`, and `rdata`=`prdata`.
  - Next state is IDLE, with `gnt`, `psel` and `penable` cleared.
- Timeout: if the counter reaches TIMEOUT-1 with `pready` low:
  - `done[owner]`=1 and `err`=1 in that cycle.
  - Next state is IDLE with `psel` dropped.
  - The counter clears on entry to SETUP.
- `paddr`, `pwrite` and `pwdata` stay frozen from grant until the return to IDLE. Input changes in that window are ignored.
- A requester must hold `req` until it sees its `done` bit, and must drop `req` on that clock edge unless it wants another transfer.
- If `req` drops mid-transfer, the transfer still completes and `done` still pulses.
- Requests that arrive outside IDLE wait; they are not lost as long as they are held.
- In every case, at most one transfer is in flight.

## Timing
- Reset (`rst_n` low at a clk edge) gives state IDLE, `last`=NREQ-1, counter 0.
- Reset values of all outputs: `psel`, `penable`, `pwrite`, `gnt`, `busy` are 0; `paddr` and `pwdata` are 0. `done` and `err` are 0 while in IDLE.
- Reset mid-transfer drops `psel` on the next cycle with no `done`.
- `req` sampled high in IDLE at edge N gives `psel`=1 in cycle N+1 and `penable`=1 in cycle N+2.
- `done` fires in the first ACCESS cycle with `pready`. Minimum latency from request to `done` is 2 cycles.
- There is at least one IDLE cycle between consecutive transfers. The next grant is decided in that IDLE cycle.
- If `pready` and timeout happen in the same cycle, `pready` wins: `err`=`pslverr`.
- The watchdog counter width is `$clog2(TIMEOUT+1)`. It saturates and never wraps.

## Structure
- A shared `eeprom_pkg` holds:
  - state encodings IDLE=0, SETUP=1, ACCESS=2 (2-bit);
  - the APB data width of 32;
  - the default TIMEOUT.
- One sub-module, `eeprom_rr_pick`: a combinational rotate-priority-rotate picker. Inputs are `req` and `last`; outputs are a one-hot winner and its index. Everything else stays in `eeprom_apb_arbiter`.

## Test plan
- **Single read.** req[0] read, addr 0x005; the slave raises `pready` on the 3rd ACCESS cycle with `prdata`=0xA5A5A5A5. Required: `psel` at N+1, `penable` at N+2, `done`=2'b01, `rdata`=0xA5A5A5A5, `err`=0, then IDLE.
- **Fairness.** req[0] and req[1] held high continuously with a 1-cycle `pready`. Grant order must be 0,1,0,1, with exactly one IDLE cycle between transfers.
- **Write stability.** req[1] write, addr 0x03F, wdata 0x11223344; `req_wdata` changes to 0 during SETUP. `pwrite`=1, `paddr`=0x03F and `pwdata`=0x11223344 must hold through ACCESS; `done`=2'b10.
- **Slave error.** `pready`=1 with `pslverr`=1 gives `done[owner]`=1 and `err`=1 for exactly one cycle.
- **Timeout.** With TIMEOUT=16 and `pready` held 0: `done`=1 and `err`=1 in the 16th ACCESS cycle, `psel`=0 the next cycle, and the next queued request is then served normally.
- **Reset mid-ACCESS.** With req[1] owning the bus, assert `rst_n`=0 for one cycle. Next cycle: `psel`=0, `gnt`=0, no `done`. After release, simultaneous req[0] and req[1] are granted to req[0] first.
